// File: rtl/yuv444_to_yuv422_pkg.sv
// Shared definitions for the YUV444 -> YUV422 stage and its output formatters.
//   DTYPE_WIDTH   width of the per-beat type code
//   DT_*          beat type codes (one image code, the rest are markers)
//   phase_t       chroma pairing phase (EVEN carries U, ODD carries V)
//   is_image()    classifies a beat type as pixel data
//   yoff()        Y offset (16 scaled to the component width)
package yuv444_to_yuv422_pkg;

  localparam int unsigned DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = 4'h1;
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = 4'h2;
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START   = 4'h3;
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END     = 4'h4;
  localparam logic [DTYPE_WIDTH-1:0] DT_IMAGE       = 4'h8;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  function automatic logic is_image(input logic [DTYPE_WIDTH-1:0] dtype);
    return dtype == DT_IMAGE;
  endfunction

  function automatic int unsigned yoff(input int unsigned pw);
    return 32'd16 << (pw - 32'd8);
  endfunction

endpackage

// File: rtl/yuv444_to_yuv422_offset_sat.sv
// yuv_offset_sat: combinational Y offset with saturation and chroma
// signed -> offset-binary conversion.
//   y      unsigned full-range Y
//   c      two's-complement chroma
//   y_off  min(y + YOFF, 2^PW-1)
//   c_off  c + 2^(PW-1) mod 2^PW (MSB flip)
module yuv_offset_sat
  import yuv444_to_yuv422_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH-1:0] y,
  input  logic [PIXEL_WIDTH-1:0] c,
  output logic [PIXEL_WIDTH-1:0] y_off,
  output logic [PIXEL_WIDTH-1:0] c_off
);

  localparam logic [PIXEL_WIDTH:0] YOFF = (PIXEL_WIDTH+1)'(yoff(PIXEL_WIDTH));

  logic [PIXEL_WIDTH:0] y_sum;

  always_comb begin
    y_sum = {1'b0, y} + YOFF;
    // carry out of the PW-bit range means the result clips to full scale
    y_off = y_sum[PIXEL_WIDTH] ? '1 : y_sum[PIXEL_WIDTH-1:0];
    c_off = {~c[PIXEL_WIDTH-1], c[PIXEL_WIDTH-2:0]};
  end

endmodule

// File: rtl/yuv444_to_yuv422.sv
// yuv444_to_yuv422: converts YUV444 (unsigned Y, signed U/V) into a
// standard-offset YUV422 stream of one {Y,C} word per pixel, 1-cycle latency.
//   clk, reset         pixel clock, asynchronous active-high reset
//   enable             1 = convert, 0 = raw bypass (pairing FSM still runs)
//   dvi/dtypei         input beat valid and type
//   yi/ui/vi           input components
//   meta_datai         sideband, delayed alongside the beat
//   dvo/dtypeo         output beat valid and type
//   yo/co              output Y and chroma (U on even pixels, held V on odd)
//   meta_datao         delayed sideband
//   odd_row            sticky flag: a row ended on an unpaired pixel
module yuv444_to_yuv422
  import yuv444_to_yuv422_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0] yi,
  input  logic [PIXEL_WIDTH-1:0] ui,
  input  logic [PIXEL_WIDTH-1:0] vi,
  input  logic [15:0]            meta_datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0] yo,
  output logic [PIXEL_WIDTH-1:0] co,
  output logic [15:0]            meta_datao,
  output logic                   odd_row
);

  phase_t                   phase, phase_d;
  logic [PIXEL_WIDTH-1:0]   v_hold, v_hold_d;
  logic                     odd_row_d;
  logic [PIXEL_WIDTH-1:0]   yo_d, co_d;
  logic [DTYPE_WIDTH-1:0]   dtypeo_d;
  logic [15:0]              meta_d;
  logic [PIXEL_WIDTH-1:0]   chroma_sel;
  logic [PIXEL_WIDTH-1:0]   y_off, c_off;

  yuv_offset_sat #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_offset_sat (
    .y    (yi),
    .c    (chroma_sel),
    .y_off(y_off),
    .c_off(c_off)
  );

  // odd pixels emit the V captured from their even partner
  always_comb begin
    chroma_sel = (phase == ODD) ? v_hold : ui;
  end

  always_comb begin
    phase_d   = phase;
    v_hold_d  = v_hold;
    odd_row_d = odd_row;
    yo_d      = yo;
    co_d      = co;
    dtypeo_d  = dtypeo;
    meta_d    = meta_datao;
    if (dvi) begin
      dtypeo_d = dtypei;
      meta_d   = meta_datai;
      if (is_image(dtypei)) begin
        unique case (phase)
          EVEN: begin
            v_hold_d = vi;
            phase_d  = ODD;
          end
          ODD: phase_d = EVEN;
          default: phase_d = EVEN;
        endcase
        // bypass is raw ui in both phases; the FSM and v_hold keep running
        yo_d = enable ? y_off : yi;
        co_d = enable ? c_off : ui;
      end else begin
        yo_d    = '0;
        co_d    = '0;
        phase_d = EVEN;
        if (phase == ODD) odd_row_d = 1'b1;
        if (dtypei == DT_FRAME_START) odd_row_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= EVEN;
      v_hold     <= '0;
      odd_row    <= 1'b0;
      dvo        <= 1'b0;
      yo         <= '0;
      co         <= '0;
      dtypeo     <= '0;
      meta_datao <= '0;
    end else begin
      phase      <= phase_d;
      v_hold     <= v_hold_d;
      odd_row    <= odd_row_d;
      dvo        <= dvi;
      yo         <= yo_d;
      co         <= co_d;
      dtypeo     <= dtypeo_d;
      meta_datao <= meta_d;
    end
  end

endmodule

// File: tb/tb_yuv444_to_yuv422.sv
module tb_yuv444_to_yuv422;
  import yuv444_to_yuv422_pkg::*;

  localparam int unsigned PW = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable, dvi, dvo, odd_row;
  logic [DTYPE_WIDTH-1:0] dtypei, dtypeo;
  logic [PW-1:0]          yi, ui, vi, yo, co;
  logic [15:0]            meta_datai, meta_datao;

  logic                   dvi10, dvo10, odd_row10;
  logic [DTYPE_WIDTH-1:0] dtypeo10;
  logic [9:0]             yi10, ui10, vi10, yo10, co10;
  logic [15:0]            meta_datao10;

  always #5 clk = ~clk;

  yuv444_to_yuv422 #(.PIXEL_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dvi(dvi), .dtypei(dtypei),
    .yi(yi), .ui(ui), .vi(vi), .meta_datai(meta_datai), .dvo(dvo),
    .dtypeo(dtypeo), .yo(yo), .co(co), .meta_datao(meta_datao), .odd_row(odd_row)
  );

  yuv444_to_yuv422 #(.PIXEL_WIDTH(10)) dut10 (
    .clk(clk), .reset(reset), .enable(1'b1), .dvi(dvi10), .dtypei(DT_IMAGE),
    .yi(yi10), .ui(ui10), .vi(vi10), .meta_datai(16'h0), .dvo(dvo10),
    .dtypeo(dtypeo10), .yo(yo10), .co(co10), .meta_datao(meta_datao10), .odd_row(odd_row10)
  );

  typedef struct {
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [15:0]            meta;
    logic [PW-1:0]          y;
    logic [PW-1:0]          c;
  } exp_t;

  typedef struct {
    logic                   en;
    logic [DTYPE_WIDTH-1:0] dtype;
    logic [7:0]             y, u, v;
    logic [7:0]             exp_y, exp_c;
    logic                   exp_odd;
  } vec_t;

  exp_t  sb[$];
  vec_t  vecs[20];
  int    checks = 0;
  int    errors = 0;
  logic [15:0] meta_cnt = 16'h100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // advance one clock and score any beat the DUT emits
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (dvo) begin
      if (sb.size() == 0) check("sb_nonempty", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        check("yo", 32'(yo), 32'(e.y));
        check("co", 32'(co), 32'(e.c));
        check("dtypeo", 32'(dtypeo), 32'(e.dtype));
        check("meta_datao", 32'(meta_datao), 32'(e.meta));
      end
    end
  endtask

  task automatic beat(input logic en, input logic valid, input logic [DTYPE_WIDTH-1:0] dt,
                      input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                      input logic [7:0] ey, input logic [7:0] ec);
    exp_t e;
    enable     = en;
    dvi        = valid;
    dtypei     = dt;
    yi         = y;
    ui         = u;
    vi         = v;
    meta_datai = meta_cnt;
    if (valid) begin
      e.dtype = dt; e.meta = meta_cnt; e.y = ey; e.c = ec;
      sb.push_back(e);
      meta_cnt++;
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // en, dtype, y, u, v, exp_y, exp_c, exp_odd   (u/v as 8-bit two's complement)
    vecs[0]  = '{1'b1, DT_FRAME_START, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0};
    vecs[1]  = '{1'b1, DT_ROW_START,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0};
    vecs[2]  = '{1'b1, DT_IMAGE,       8'd100, 8'd246, 8'd20,  8'd116, 8'd118, 1'b0};
    vecs[3]  = '{1'b1, DT_IMAGE,       8'd50,  8'd99,  8'd157, 8'd66,  8'd148, 1'b0};
    vecs[4]  = '{1'b1, DT_IMAGE,       8'd250, 8'd128, 8'd5,   8'd255, 8'd0,   1'b0};
    vecs[5]  = '{1'b1, DT_IMAGE,       8'd0,   8'd0,   8'd127, 8'd16,  8'd133, 1'b0};
    vecs[6]  = '{1'b1, DT_IMAGE,       8'd239, 8'd127, 8'd0,   8'd255, 8'd255, 1'b0};
    vecs[7]  = '{1'b1, DT_IMAGE,       8'd240, 8'd1,   8'd255, 8'd255, 8'd128, 1'b0};
    vecs[8]  = '{1'b1, DT_ROW_END,     8'd9,   8'd9,   8'd9,   8'd0,   8'd0,   1'b0};
    vecs[9]  = '{1'b1, DT_ROW_START,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0};
    vecs[10] = '{1'b1, DT_IMAGE,       8'd1,   8'd10,  8'd20,  8'd17,  8'd138, 1'b0};
    vecs[11] = '{1'b1, DT_IMAGE,       8'd2,   8'd30,  8'd40,  8'd18,  8'd148, 1'b0};
    vecs[12] = '{1'b1, DT_IMAGE,       8'd3,   8'd50,  8'd60,  8'd19,  8'd178, 1'b0};
    vecs[13] = '{1'b1, DT_ROW_END,     8'd7,   8'd7,   8'd7,   8'd0,   8'd0,   1'b1};
    vecs[14] = '{1'b0, DT_IMAGE,       8'd7,   8'd253, 8'd66,  8'd7,   8'd253, 1'b1};
    vecs[15] = '{1'b1, DT_IMAGE,       8'd9,   8'd1,   8'd2,   8'd25,  8'd194, 1'b1};
    vecs[16] = '{1'b0, DT_IMAGE,       8'd200, 8'd33,  8'd44,  8'd200, 8'd33,  1'b1};
    vecs[17] = '{1'b0, DT_IMAGE,       8'd201, 8'd55,  8'd66,  8'd201, 8'd55,  1'b1};
    vecs[18] = '{1'b1, DT_ROW_END,     8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b1};
    vecs[19] = '{1'b1, DT_FRAME_START, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   1'b0};

    reset = 1'b1; enable = 1'b1; dvi = 1'b0; dtypei = '0;
    yi = '0; ui = '0; vi = '0; meta_datai = 16'hFFFF;
    dvi10 = 1'b0; yi10 = '0; ui10 = '0; vi10 = '0;
    #12;
    check("rst_yo", 32'(yo), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_dvo", 32'(dvo), 32'd0);
    check("rst_dtypeo", 32'(dtypeo), 32'd0);
    check("rst_meta", 32'(meta_datao), 32'd0);
    check("rst_odd_row", 32'(odd_row), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 20; i++) begin
      beat(vecs[i].en, 1'b1, vecs[i].dtype, vecs[i].y, vecs[i].u, vecs[i].v,
           vecs[i].exp_y, vecs[i].exp_c);
      check($sformatf("odd_row_v%0d", i), 32'(odd_row), 32'(vecs[i].exp_odd));
    end

    // gaps between an even/odd pair: outputs hold, dvo follows dvi
    beat(1'b1, 1'b1, DT_IMAGE, 8'd10, 8'd4, 8'd8, 8'd26, 8'd132);
    for (int g = 0; g < 2; g++) begin
      beat(1'b1, 1'b0, DT_IMAGE, 8'd99, 8'd99, 8'd99, 8'd0, 8'd0);
      check("gap_dvo", 32'(dvo), 32'd0);
      check("gap_yo_hold", 32'(yo), 32'd26);
      check("gap_co_hold", 32'(co), 32'd132);
      check("gap_meta_hold", 32'(meta_datao), 32'(meta_cnt - 16'd1));
    end
    beat(1'b1, 1'b1, DT_IMAGE, 8'd20, 8'd0, 8'd0, 8'd36, 8'd136);

    // single-pixel row sets odd_row, then reset mid-row while ODD
    beat(1'b1, 1'b1, DT_IMAGE, 8'd1, 8'd2, 8'd3, 8'd17, 8'd130);
    beat(1'b1, 1'b1, DT_ROW_END, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    check("odd_row_single", 32'(odd_row), 32'd1);
    beat(1'b1, 1'b1, DT_IMAGE, 8'd10, 8'd4, 8'd8, 8'd26, 8'd132);
    dvi = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_yo", 32'(yo), 32'd0);
    check("async_rst_co", 32'(co), 32'd0);
    check("async_rst_odd_row", 32'(odd_row), 32'd0);
    #4 reset = 1'b0;
    beat(1'b1, 1'b1, DT_IMAGE, 8'd5, 8'd1, 8'd2, 8'd21, 8'd129);

    // 10-bit instance: offset scaling and saturation
    dvi = 1'b0;
    dvi10 = 1'b1; yi10 = 10'd1000; ui10 = 10'h200; vi10 = 10'd0;
    tick();
    check("pw10_dvo", 32'(dvo10), 32'd1);
    check("pw10_y_sat", 32'(yo10), 32'd1023);
    check("pw10_c_min", 32'(co10), 32'd0);
    yi10 = 10'd0; ui10 = 10'd77; vi10 = 10'd33;
    tick();
    check("pw10_y_zero", 32'(yo10), 32'd64);
    check("pw10_c_odd", 32'(co10), 32'd512);
    dvi10 = 1'b0;
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
